// File: rtl/du_dump_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : du_dump_serializer
//  Description : Snapshots a 32-bit word or the pipeline latch vector and
//                feeds it to the UART TX one byte at a time, LSB first.
//  Revision    : 1.0 - initial release
// ============================================================================
module du_dump_serializer #(
    parameter int NB_REG   = 32,
    parameter int NB_R_INT = 341,
    parameter int NB_DATA  = 8
) (
    input  logic                i_du_clk,
    input  logic                i_du_reset,
    input  logic                i_dump_start,
    input  logic                i_dump_sel,
    input  logic [NB_REG-1:0]   i_word_data,
    input  logic [NB_R_INT-1:0] i_latches_data,
    input  logic                i_tx_done,
    output logic                o_tx_start,
    output logic [NB_DATA-1:0]  o_tx_data,
    output logic                o_busy,
    output logic                o_dump_done
);

    localparam int         NB_SNAP     = ((NB_R_INT + NB_DATA - 1) / NB_DATA) * NB_DATA;
    localparam logic [5:0] WORD_BYTES  = 6'(NB_REG / NB_DATA);
    localparam logic [5:0] LATCH_BYTES = 6'(NB_SNAP / NB_DATA);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NB_SNAP-1:0]   snap_q, snap_d;
    logic [5:0]           cnt_q, cnt_d;
    logic                 tx_start_q, tx_start_d;
    logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
    logic                 busy_q, busy_d;
    logic                 dump_done_q, dump_done_d;

    logic [NB_SNAP-1:0]   load_snap;
    logic [NB_SNAP-1:0]   shifted_snap;

    always_comb begin
        if (i_dump_sel) begin
            load_snap = {{(NB_SNAP - NB_R_INT){1'b0}}, i_latches_data};
        end else begin
            load_snap = {{(NB_SNAP - NB_REG){1'b0}}, i_word_data};
        end
        shifted_snap = snap_q >> NB_DATA;
    end

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        cnt_d       = cnt_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        busy_d      = busy_q;
        dump_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (i_dump_start) begin
                    snap_d     = load_snap;
                    cnt_d      = i_dump_sel ? LATCH_BYTES : WORD_BYTES;
                    tx_start_d = 1'b1;
                    tx_data_d  = load_snap[NB_DATA-1:0];
                    busy_d     = 1'b1;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done) begin
                    snap_d = shifted_snap;
                    cnt_d  = cnt_q - 6'd1;
                    // Output byte is only refreshed when another byte follows,
                    // so the last byte stays on the bus through DONE.
                    if (cnt_q == 6'd1) begin
                        dump_done_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        tx_start_d = 1'b1;
                        tx_data_d  = shifted_snap[NB_DATA-1:0];
                        state_d    = ST_SEND;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_du_clk) begin
        if (i_du_reset) begin
            state_q     <= ST_IDLE;
            snap_q      <= '0;
            cnt_q       <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            busy_q      <= 1'b0;
            dump_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            cnt_q       <= cnt_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            dump_done_q <= dump_done_d;
        end
    end

    assign o_tx_start  = tx_start_q;
    assign o_tx_data   = tx_data_q;
    assign o_busy      = busy_q;
    assign o_dump_done = dump_done_q;

endmodule
`default_nettype wire
